// File: rtl/sram_core_pkg.sv
// sram_core_pkg: state encodings, read latency and default widths shared by sram_core and its bench
package sram_core_pkg;
   localparam int SRAM_RD_LATENCY = 4;
   localparam int SRAM_ADDR_WIDTH = 18;
   localparam int SRAM_DATA_WIDTH = 16;
   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
endpackage

// File: rtl/sram_core.sv
// sram_core: single-command responder driving a 256K x 16 asynchronous SRAM, read data 4 cycles after accept
// SRAM_CORE_TURNAROUND_EN: hold off a write for one idle bus cycle directly after a read
module sram_core import sram_core_pkg::*; #(
   parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = SRAM_DATA_WIDTH
) (
   input  logic                  a_clk,
   input  logic                  a_rst,
   input  logic                  sram_req,
   output logic                  sram_ready,
   input  logic                  sram_rd,
   input  logic [ADDR_WIDTH-1:0] sram_addr,
   input  logic [1:0]            sram_be,
   input  logic [DATA_WIDTH-1:0] sram_wr_data,
   output logic                  sram_rd_data_vld,
   output logic [DATA_WIDTH-1:0] sram_rd_data,
   output logic [ADDR_WIDTH-1:0] pin_addr,
   output logic [DATA_WIDTH-1:0] pin_data_out,
   output logic                  pin_data_oe,
   input  logic [DATA_WIDTH-1:0] pin_data_in,
   output logic                  pin_cs_n,
   output logic                  pin_we_n,
   output logic                  pin_oe_n,
   output logic                  pin_lb_n,
   output logic                  pin_ub_n
);
   state_t state, ns;
   logic [1:0] be;
   logic block, rd_next, wr_next;
`ifdef SRAM_CORE_TURNAROUND_EN
   assign block = sram_rd_data_vld & ~sram_rd;
`else
   assign block = 1'b0;
`endif
   assign sram_ready = sram_req & (state == IDLE) & ~a_rst & ~block;
   always_comb begin
      ns = state;
      case (state)
         IDLE:      ns = sram_ready ? (sram_rd ? RD_ADDR : WR_SETUP) : IDLE;
         RD_ADDR:   ns = RD_WAIT;
         RD_WAIT:   ns = RD_SAMPLE;
         RD_SAMPLE: ns = IDLE;
         WR_SETUP:  ns = WR_PULSE;
         WR_PULSE:  ns = WR_HOLD;
         WR_HOLD:   ns = IDLE;
         default:   ns = IDLE;
      endcase
   end
   assign rd_next = ns inside {RD_ADDR, RD_WAIT, RD_SAMPLE};
   assign wr_next = ns inside {WR_SETUP, WR_PULSE, WR_HOLD};
   // pins are registered from the next state so they change cleanly on the clock edge
   always_ff @(posedge a_clk or posedge a_rst)
      if (a_rst) begin
         state            <= IDLE;
         be               <= '0;
         pin_addr         <= '0;
         pin_data_out     <= '0;
         pin_data_oe      <= 1'b0;
         pin_cs_n         <= 1'b1;
         pin_we_n         <= 1'b1;
         pin_oe_n         <= 1'b1;
         pin_lb_n         <= 1'b1;
         pin_ub_n         <= 1'b1;
         sram_rd_data     <= '0;
         sram_rd_data_vld <= 1'b0;
      end else begin
         state <= ns;
         if (sram_ready) begin
            be       <= sram_be;
            pin_addr <= sram_addr;
         end
         if (sram_ready & ~sram_rd) pin_data_out <= sram_wr_data;
         pin_cs_n         <= ns == IDLE;
         pin_oe_n         <= ~rd_next;
         pin_data_oe      <= wr_next;
         pin_we_n         <= ns != WR_PULSE;
         pin_lb_n         <= ~(rd_next | (ns == WR_PULSE & be[0]));
         pin_ub_n         <= ~(rd_next | (ns == WR_PULSE & be[1]));
         sram_rd_data_vld <= state == RD_SAMPLE;
         if (state == RD_SAMPLE) sram_rd_data <= pin_data_in;
      end
endmodule
